// File: rtl/group_add_stream.sv
// Streaming signed group adder: sums GROUP_NB operands per beat through a
// pipelined binary adder tree, then saturates or wraps into NUM_WIDTH bits.
module group_add_stream #(
    parameter int GROUP_NB  = 3,
    parameter int NUM_WIDTH = 16,
    parameter int SATURATE  = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_WIDTH*GROUP_NB-1:0] up_data,
    input  logic                          up_val,
    output logic                          up_rdy,
    output logic [NUM_WIDTH-1:0]          dn_data,
    output logic                          dn_ovf,
    output logic                          dn_val,
    input  logic                          dn_rdy
);

    localparam int LEVELS = (GROUP_NB > 1) ? $clog2(GROUP_NB) : 0;
    localparam int SW     = NUM_WIDTH + LEVELS;

    localparam logic signed [SW-1:0] SUM_MAX = {{(LEVELS+1){1'b0}}, {(NUM_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SUM_MIN = {{(LEVELS+1){1'b1}}, {(NUM_WIDTH-1){1'b0}}};

    // Number of live operands at tree level l (level 0 is the raw input).
    function automatic int lvl_cnt(input int l);
        return (GROUP_NB + (1 << l) - 1) >> l;
    endfunction

    logic en;

    assign en     = !dn_val || dn_rdy;
    assign up_rdy = en;

    genvar gi, gj;
    generate
        for (gi = 0; gi <= LEVELS; gi++) begin : g_lvl
            localparam int CNT = lvl_cnt(gi);

            logic vld;

            if (gi == 0) begin : g_vin
                assign vld = up_val;
            end else begin : g_vreg
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        vld <= 1'b0;
                    end else if (en) begin
                        vld <= g_lvl[gi-1].vld;
                    end
                end
            end

            for (gj = 0; gj < CNT; gj++) begin : g_node
                logic signed [SW-1:0] q;

                if (gi == 0) begin : g_src
                    assign q = SW'(signed'(up_data[gj*NUM_WIDTH +: NUM_WIDTH]));
                end else if (2*gj + 1 < lvl_cnt(gi-1)) begin : g_add
                    // Data registers are left unreset; the valid bits qualify them.
                    always_ff @(posedge clk) begin
                        if (en) begin
                            q <= g_lvl[gi-1].g_node[2*gj].q + g_lvl[gi-1].g_node[2*gj+1].q;
                        end
                    end
                end else begin : g_pass
                    always_ff @(posedge clk) begin
                        if (en) begin
                            q <= g_lvl[gi-1].g_node[2*gj].q;
                        end
                    end
                end
            end
        end
    endgenerate

    logic signed [SW-1:0]  full_sum;
    logic                  full_vld;
    logic                  ovf_next;
    logic [NUM_WIDTH-1:0]  res_next;

    assign full_sum = g_lvl[LEVELS].g_node[0].q;
    assign full_vld = g_lvl[LEVELS].vld;

    always_comb begin
        ovf_next = (full_sum > SUM_MAX) || (full_sum < SUM_MIN);
        res_next = full_sum[NUM_WIDTH-1:0];
        if ((SATURATE != 0) && ovf_next) begin
            res_next = full_sum[SW-1] ? {1'b1, {(NUM_WIDTH-1){1'b0}}}
                                      : {1'b0, {(NUM_WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dn_val  <= 1'b0;
            dn_ovf  <= 1'b0;
            dn_data <= '0;
        end else if (en) begin
            dn_val  <= full_vld;
            dn_ovf  <= full_vld && ovf_next;
            dn_data <= res_next;
        end
    end

endmodule

// File: tb/tb_group_add_stream.sv
// Directed bench for group_add_stream: a saturating and a wrapping instance
// share one stimulus stream; sums are hand-computed constants.
module tb_group_add_stream;

    localparam int NW = 16;
    localparam int NB = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NW*NB-1:0] up_data;
    logic             up_val;
    logic             dn_rdy;

    logic             up_rdy_s, dn_val_s, dn_ovf_s;
    logic [NW-1:0]    dn_data_s;
    logic             up_rdy_w, dn_val_w, dn_ovf_w;
    logic [NW-1:0]    dn_data_w;

    int total = 0;
    int bad   = 0;

    logic [NW*NB-1:0] beats[$];
    logic [NW-1:0]    got_s[$];
    logic [NW-1:0]    got_w[$];
    logic             got_ovf_s[$];
    logic             got_ovf_w[$];
    int               first_out;
    int               last_out;

    always #5 clk = ~clk;

    group_add_stream #(.GROUP_NB(NB), .NUM_WIDTH(NW), .SATURATE(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .up_data(up_data), .up_val(up_val), .up_rdy(up_rdy_s),
        .dn_data(dn_data_s), .dn_ovf(dn_ovf_s), .dn_val(dn_val_s), .dn_rdy(dn_rdy)
    );

    group_add_stream #(.GROUP_NB(NB), .NUM_WIDTH(NW), .SATURATE(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .up_data(up_data), .up_val(up_val), .up_rdy(up_rdy_w),
        .dn_data(dn_data_w), .dn_ovf(dn_ovf_w), .dn_val(dn_val_w), .dn_rdy(dn_rdy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NW*NB-1:0] pk(input logic [NW-1:0] a, input logic [NW-1:0] b,
                                            input logic [NW-1:0] c);
        return {a, b, c};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feeds the beats queue as fast as up_rdy allows, optionally dropping
    // dn_rdy for stall_len cycles from cycle stall_at, and records every transfer.
    task automatic run_stream(input int stall_at, input int stall_len, input int ncyc);
        int          idx = 0;
        logic        prev_stall = 1'b0;
        logic [NW-1:0] prev_data = '0;
        got_s.delete();
        got_w.delete();
        got_ovf_s.delete();
        got_ovf_w.delete();
        first_out = -1;
        last_out  = -1;
        for (int c = 0; c < ncyc; c++) begin
            dn_rdy  = !((c >= stall_at) && (c < stall_at + stall_len));
            up_val  = (idx < beats.size());
            up_data = up_val ? beats[idx] : '0;
            #1;
            if (prev_stall) begin
                check_val("hold_data", dn_data_s, prev_data);
                check_val("hold_val", dn_val_s, 1);
            end
            prev_stall = dn_val_s && !dn_rdy;
            prev_data  = dn_data_s;
            if (prev_stall) check_val("stall_up_rdy", up_rdy_s, 0);
            if (dn_val_s && dn_rdy) begin
                got_s.push_back(dn_data_s);
                got_ovf_s.push_back(dn_ovf_s);
                if (first_out < 0) first_out = c;
                last_out = c;
                $display("cycle %0d: out data=%h ovf=%b", c, dn_data_s, dn_ovf_s);
            end
            if (dn_val_w && dn_rdy) begin
                got_w.push_back(dn_data_w);
                got_ovf_w.push_back(dn_ovf_w);
            end
            if (up_val && up_rdy_s) idx++;
            tick();
        end
        up_val = 1'b0;
        dn_rdy = 1'b1;
    endtask

    task automatic check_seq(input string tag, input logic [NW-1:0] exp_s[$], input logic exp_ovf[$]);
        check_val({tag, "_count"}, got_s.size(), exp_s.size());
        for (int i = 0; i < exp_s.size(); i++) begin
            if (i < got_s.size()) begin
                check_val({tag, "_data"}, got_s[i], exp_s[i]);
                check_val({tag, "_ovf"}, got_ovf_s[i], exp_ovf[i]);
            end
        end
    endtask

    task automatic single_beat(input logic [NW*NB-1:0] d, input logic [NW-1:0] exp, input string tag);
        up_data = d;
        up_val  = 1'b1;
        dn_rdy  = 1'b1;
        #1;
        check_val({tag, "_up_rdy"}, up_rdy_s, 1);
        tick();
        up_val = 1'b0;
        check_val({tag, "_lat1"}, dn_val_s, 0);
        tick();
        check_val({tag, "_lat2"}, dn_val_s, 0);
        tick();
        check_val({tag, "_val"}, dn_val_s, 1);
        check_val({tag, "_data"}, dn_data_s, exp);
        check_val({tag, "_ovf"}, dn_ovf_s, 0);
        $display("single %s: out data=%h ovf=%b", tag, dn_data_s, dn_ovf_s);
        tick();
        check_val({tag, "_pulse"}, dn_val_s, 0);
    endtask

    logic [NW-1:0] exp_b2b[$];
    logic          exp_zero[$];
    logic [NW-1:0] exp_sat[$];
    logic [NW-1:0] exp_wrap[$];
    logic          exp_ovf3[$];

    initial begin
        rst_n   = 1'b0;
        up_val  = 1'b0;
        up_data = '0;
        dn_rdy  = 1'b1;
        exp_b2b  = '{16'h0600, 16'h0F00, 16'h1800, 16'h2100, 16'h2A00};
        exp_zero = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_sat  = '{16'h7FFF, 16'h8000, 16'h0000};
        exp_wrap = '{16'h7D00, 16'h8000, 16'h0000};
        exp_ovf3 = '{1'b1, 1'b1, 1'b0};

        repeat (2) tick();
        check_val("rst_dn_val", dn_val_s, 0);
        check_val("rst_dn_data", dn_data_s, 0);
        check_val("rst_dn_ovf", dn_ovf_s, 0);
        check_val("rst_up_rdy", up_rdy_s, 1);
        rst_n = 1'b1;
        tick();

        single_beat(pk(16'h0300, 16'h0200, 16'h0100), 16'h0600, "single");

        beats = '{pk(16'h0300, 16'h0200, 16'h0100), pk(16'h0600, 16'h0500, 16'h0400),
                  pk(16'h0900, 16'h0800, 16'h0700), pk(16'h0C00, 16'h0B00, 16'h0A00),
                  pk(16'h0F00, 16'h0E00, 16'h0D00)};
        run_stream(1000, 0, 20);
        check_seq("b2b", exp_b2b, exp_zero);
        check_val("b2b_first", first_out, 3);
        check_val("b2b_last", last_out, 7);

        run_stream(4, 4, 25);
        check_seq("stall", exp_b2b, exp_zero);
        check_val("stall_first", first_out, 3);
        check_val("stall_last", last_out, 11);

        beats = '{pk(16'h7F00, 16'h7F00, 16'h7F00), pk(16'h8000, 16'h8000, 16'h8000),
                  pk(16'h8000, 16'h7FFF, 16'h0001)};
        run_stream(1000, 0, 15);
        check_seq("sat", exp_sat, exp_ovf3);
        check_val("wrap_count", got_w.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < got_w.size()) begin
                check_val("wrap_data", got_w[i], exp_wrap[i]);
                check_val("wrap_ovf", got_ovf_w[i], exp_ovf3[i]);
            end
        end

        // Two beats in flight, first one parked at the output by a stall.
        dn_rdy  = 1'b0;
        up_val  = 1'b1;
        up_data = pk(16'h0100, 16'h0200, 16'h0300);
        tick();
        up_data = pk(16'h0400, 16'h0500, 16'h0600);
        tick();
        up_val = 1'b0;
        tick();
        check_val("pre_rst_val", dn_val_s, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_val", dn_val_s, 0);
        check_val("async_rst_data", dn_data_s, 0);
        check_val("async_rst_up_rdy", up_rdy_s, 1);
        tick();
        rst_n  = 1'b1;
        dn_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("no_stale", dn_val_s, 0);
        end
        single_beat(pk(16'h0100, 16'h0100, 16'h0100), 16'h0300, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/group_add_stream.md
GROUP_ADD_STREAM -- requirements
Module: group_add_stream

Interface
REQ-001 Parameter GROUP_NB, default 3, number of signed operands summed per beat (>=1).
REQ-002 Parameter NUM_WIDTH, default 16, width of each signed two's-complement operand and of the result; fixed-point position is irrelevant to the block.
REQ-003 Parameter SATURATE, default 1; 1 = clamp result to NUM_WIDTH range, 0 = wrap (keep low NUM_WIDTH bits).
REQ-004 Port clk  input  1  single clock; all state on rising edge.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port up_data  input  NUM_WIDTH*GROUP_NB  operands; operand k at bits [k*NUM_WIDTH +: NUM_WIDTH].
REQ-007 Port up_val  input  1  up_data valid.
REQ-008 Port up_rdy  output  1  block accepts up_data this cycle.
REQ-009 Port dn_data  output  NUM_WIDTH  signed sum.
REQ-010 Port dn_ovf  output  1  full-precision sum did not fit NUM_WIDTH; qualified by dn_val.
REQ-011 Port dn_val  output  1  dn_data/dn_ovf valid.
REQ-012 Port dn_rdy  input  1  downstream accepts dn_data this cycle.

Function
REQ-013 Beat accepted upstream when up_val && up_rdy; transferred downstream when dn_val && dn_rdy.
REQ-014 LEVELS = ceil(log2(GROUP_NB)) (0 when GROUP_NB=1); pipelined binary adder tree, one register stage per level, plus one output stage.
REQ-015 Each tree stage carries a valid bit; odd operand at a level passes through registered, unmodified.
REQ-016 Internal sums use NUM_WIDTH+LEVELS bits with sign extension; no overflow inside the tree.
REQ-017 Output stage: if full sum > 2^(NUM_WIDTH-1)-1 or < -2^(NUM_WIDTH-1), dn_ovf=1; dn_data = clamped extreme when SATURATE=1, low NUM_WIDTH bits when SATURATE=0; otherwise dn_ovf=0, dn_data = exact sum.
REQ-018 Pipeline enable en = !dn_val || dn_rdy; all stages (data and valid) advance only when en=1, otherwise hold.
REQ-019 up_rdy = en (combinational); up_val is not required to wait for up_rdy.
REQ-020 Latency: beat accepted at edge N appears on dn_val/dn_data after edge N+LEVELS+1 with dn_rdy held high (3 cycles for GROUP_NB=3).
REQ-021 Throughput: one beat per cycle sustained while dn_rdy=1; no bubbles inserted, no beats dropped or duplicated.
REQ-022 Stall: while dn_val=1 and dn_rdy=0, dn_data, dn_ovf, dn_val stay stable and up_rdy=0.
REQ-023 Cycles with up_val=0 while en=1 insert bubbles (valid=0) that propagate; dn_val=0 for those slots.
REQ-024 Beats leave in acceptance order.
REQ-025 GROUP_NB=1: dn_data = operand after 1 cycle, dn_ovf always 0.

Reset
REQ-026 rst_n low asynchronously clears all stage valid bits, dn_val=0, dn_ovf=0, dn_data=0; up_rdy=1 while reset is low.
REQ-027 Reset mid-operation discards all in-flight beats; first beat accepted after release appears after LEVELS+1 cycles.
REQ-028 Tree data registers need not be reset; only valid bits and outputs are reset.

Verification (GROUP_NB=3, NUM_WIDTH=16, 8 fractional bits in bench)
REQ-029 Single beat {3.0,2.0,1.0} (0x0300,0x0200,0x0100), dn_rdy=1 -> dn_data=0x0600, dn_ovf=0, dn_val high one cycle, 3 cycles after acceptance.
REQ-030 Back-to-back {3,2,1},{6,5,4},{9,8,7},{12,11,10},{15,14,13} -> dn_data 6,15,24,33,42 (0x0600,0x0F00,0x1800,0x2100,0x2A00) on 5 consecutive cycles.
REQ-031 Same stream with dn_rdy low 4 cycles mid-burst -> up_rdy low during stall, dn_data held, all 5 sums delivered in order exactly once.
REQ-032 SATURATE=1, {0x7F00,0x7F00,0x7F00} -> 0x7FFF, dn_ovf=1; {0x8000,0x8000,0x8000} -> 0x8000, dn_ovf=1; {0x8000,0x7FFF,0x0001} -> 0x0000, dn_ovf=0.
REQ-033 SATURATE=0, {0x7F00,0x7F00,0x7F00} -> 0x7D00, dn_ovf=1.
REQ-034 Assert rst_n low with 2 beats in flight -> dn_val=0 immediately; no stale output after release; fresh {1,1,1} -> 0x0300 after 3 cycles.
